// File: rtl/pla_sweep_pkg.sv
// Shared types and constants for the PLA exhaustive-sweep controller.
package pla_sweep_pkg;

   localparam int unsigned VEC_W  = 8;
   localparam int unsigned RESP_W = 31;
   localparam int unsigned SIG_W  = 32;

   localparam logic [SIG_W-1:0] MISR_POLY_DEF = 32'h04C11DB7;
   localparam logic [SIG_W-1:0] MISR_SEED_DEF = 32'hFFFFFFFF;

   typedef enum logic [1:0] {
      IDLE,
      APPLY,
      CAPTURE,
      DONE
   } state_e;

endpackage

// File: rtl/misr32_step.sv
// One combinational MISR step: shift with polynomial feedback, then fold in the response.
module misr32_step
   import pla_sweep_pkg::*;
(
   input  logic [SIG_W-1:0]  misr,
   input  logic [RESP_W-1:0] resp,
   input  logic [SIG_W-1:0]  poly,
   output logic [SIG_W-1:0]  misr_next
);

   assign misr_next = ({misr[SIG_W-2:0], 1'b0} ^ (misr[SIG_W-1] ? poly : '0)) ^ {1'b0, resp};

endmodule

// File: rtl/pla_sweep_ctrl.sv
// Walks every PLA input vector, compacting the responses into a MISR signature.
// Optional output-toggle counter enabled by defining SWEEP_TOGGLE_CNT_EN.
module pla_sweep_ctrl
   import pla_sweep_pkg::*;
#(
   parameter int unsigned      SETTLE    = 1,
   parameter logic [VEC_W-1:0] LAST_VEC  = 8'hFF,
   parameter logic [SIG_W-1:0] MISR_POLY = MISR_POLY_DEF,
   parameter logic [SIG_W-1:0] MISR_SEED = MISR_SEED_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              abort_i,
   output logic [VEC_W-1:0]  vec_o,
   input  logic [RESP_W-1:0] resp_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              sig_valid_o,
   output logic [SIG_W-1:0]  signature_o
`ifdef SWEEP_TOGGLE_CNT_EN
   ,
   output logic [15:0]       toggle_cnt_o
`endif
);

   state_e           state;
   logic [3:0]       settle;
   logic [SIG_W-1:0] misr;
   logic [SIG_W-1:0] misr_next;

   misr32_step u_misr32_step (
      .misr      (misr),
      .resp      (resp_i),
      .poly      (MISR_POLY),
      .misr_next (misr_next)
   );

`ifdef SWEEP_TOGGLE_CNT_EN
   logic [RESP_W-1:0] prev_resp;
   logic              first_cap;
   logic [5:0]        pop;
   logic [16:0]       cnt_sum;

   always_comb begin
      pop = '0;
      for (int i = 0; i < RESP_W; i++) begin
         pop = pop + 6'(resp_i[i] ^ prev_resp[i]);
      end
      cnt_sum = {1'b0, toggle_cnt_o} + 17'(pop);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         settle      <= '0;
         misr        <= '0;
         vec_o       <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         sig_valid_o <= 1'b0;
         signature_o <= '0;
`ifdef SWEEP_TOGGLE_CNT_EN
         toggle_cnt_o <= '0;
         prev_resp    <= '0;
         first_cap    <= 1'b0;
`endif
      end else begin
         done_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start_i) begin
                  state       <= APPLY;
                  vec_o       <= '0;
                  misr        <= MISR_SEED;
                  settle      <= 4'(SETTLE);
                  sig_valid_o <= 1'b0;
                  busy_o      <= 1'b1;
`ifdef SWEEP_TOGGLE_CNT_EN
                  toggle_cnt_o <= '0;
                  first_cap    <= 1'b1;
`endif
               end
            end
            APPLY: begin
               if (abort_i) begin
                  state       <= IDLE;
                  busy_o      <= 1'b0;
                  sig_valid_o <= 1'b0;
               end else if (settle == 4'd1) begin
                  state <= CAPTURE;
               end else begin
                  settle <= settle - 4'd1;
               end
            end
            CAPTURE: begin
               // Abort wins over the capture, so a cancelled sweep never folds in this vector.
               if (abort_i) begin
                  state       <= IDLE;
                  busy_o      <= 1'b0;
                  sig_valid_o <= 1'b0;
               end else begin
                  misr <= misr_next;
`ifdef SWEEP_TOGGLE_CNT_EN
                  prev_resp <= resp_i;
                  first_cap <= 1'b0;
                  if (!first_cap) begin
                     toggle_cnt_o <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
                  end
`endif
                  if (vec_o == LAST_VEC) begin
                     state  <= DONE;
                     busy_o <= 1'b0;
                  end else begin
                     state  <= APPLY;
                     vec_o  <= vec_o + 8'd1;
                     settle <= 4'(SETTLE);
                  end
               end
            end
            DONE: begin
               state       <= IDLE;
               done_o      <= 1'b1;
               signature_o <= misr;
               sig_valid_o <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// Self-checking bench: three controller instances (single vector, full sweep, 4-vector sweep).
module tb_pla_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_a, abort_a, start_b, abort_b, start_c, abort_c;
   logic [7:0]  vec_a, vec_b, vec_c;
   logic [30:0] resp_a, resp_b, resp_c;
   logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
   logic        sigv_a, sigv_b, sigv_c;
   logic [31:0] sig_a, sig_b, sig_c;
`ifdef SWEEP_TOGGLE_CNT_EN
   logic [15:0] tog_a, tog_b, tog_c;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] sig_q[$];
   int          lat_q[$];

   always #5 clk = ~clk;

   function automatic logic [30:0] resp_map(input logic [7:0] v);
      return {v[6:0], v, v, v} ^ 31'h12345678;
   endfunction

   function automatic logic [31:0] model_sig(input int last, input int sel);
      logic [31:0] m;
      logic [30:0] r;
      logic [7:0]  v;
      m = 32'hFFFFFFFF;
      for (int i = 0; i <= last; i++) begin
         v = 8'(i);
         case (sel)
            0:       r = '0;
            1:       r = resp_map(v);
            default: r = {31{v[0]}};
         endcase
         m = ({m[30:0], 1'b0} ^ (m[31] ? 32'h04C11DB7 : 32'h0)) ^ {1'b0, r};
      end
      return m;
   endfunction

   assign resp_a = '0;
   assign resp_b = resp_map(vec_b);
   assign resp_c = {31{vec_c[0]}};

   pla_sweep_ctrl #(.SETTLE(1), .LAST_VEC(8'h00)) dut_a (
      .clk(clk), .rst(rst), .start_i(start_a), .abort_i(abort_a), .vec_o(vec_a),
      .resp_i(resp_a), .busy_o(busy_a), .done_o(done_a), .sig_valid_o(sigv_a),
      .signature_o(sig_a)
`ifdef SWEEP_TOGGLE_CNT_EN
      , .toggle_cnt_o(tog_a)
`endif
   );

   pla_sweep_ctrl #(.SETTLE(2), .LAST_VEC(8'hFF)) dut_b (
      .clk(clk), .rst(rst), .start_i(start_b), .abort_i(abort_b), .vec_o(vec_b),
      .resp_i(resp_b), .busy_o(busy_b), .done_o(done_b), .sig_valid_o(sigv_b),
      .signature_o(sig_b)
`ifdef SWEEP_TOGGLE_CNT_EN
      , .toggle_cnt_o(tog_b)
`endif
   );

   pla_sweep_ctrl #(.SETTLE(1), .LAST_VEC(8'h03)) dut_c (
      .clk(clk), .rst(rst), .start_i(start_c), .abort_i(abort_c), .vec_o(vec_c),
      .resp_i(resp_c), .busy_o(busy_c), .done_o(done_c), .sig_valid_o(sigv_c),
      .signature_o(sig_c)
`ifdef SWEEP_TOGGLE_CNT_EN
      , .toggle_cnt_o(tog_c)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pops the scoreboard entry for dut_b and compares latency, signature and valid.
   task automatic finish_b(input string name, input int k);
      logic [31:0] es;
      int          el;
      es = sig_q.pop_front();
      el = lat_q.pop_front();
      checks++;
      if (k !== el) begin
         $display("FAIL %s latency: got %0d cycles, expected %0d", name, k, el);
         errors++;
      end
      checks++;
      if (sig_b !== es || sigv_b !== 1'b1) begin
         $display("FAIL %s signature: got %h valid %b, expected %h valid 1", name, sig_b,
                  sigv_b, es);
         errors++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start_a = 0; abort_a = 0; start_b = 0; abort_b = 0; start_c = 0; abort_c = 0;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if ({vec_a, vec_b, vec_c} !== 24'h0) begin
         $display("FAIL reset_vec: got %h, expected 0", {vec_a, vec_b, vec_c});
         errors++;
      end
      checks++;
      if ({busy_a, busy_b, busy_c, done_a, done_b, done_c, sigv_a, sigv_b, sigv_c} !== 9'h0) begin
         $display("FAIL reset_flags: got %b, expected 0",
                  {busy_a, busy_b, busy_c, done_a, done_b, done_c, sigv_a, sigv_b, sigv_c});
         errors++;
      end
      checks++;
      if ({sig_a, sig_b, sig_c} !== 96'h0) begin
         $display("FAIL reset_sig: got %h, expected 0", {sig_a, sig_b, sig_c});
         errors++;
      end
   endtask

   task automatic test_single_vector();
      int k;
      sig_q.push_back(32'hFB3EE249);
      lat_q.push_back(3);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      k = 0;
      checks++;
      if (busy_a !== 1'b1) begin
         $display("FAIL single_busy: got %b, expected 1", busy_a);
         errors++;
      end
      while (!done_a && k < 20) begin
         tick();
         k++;
      end
      checks++;
      if (k >= 20) begin
         $display("FAIL single_timeout: done_o not seen in %0d cycles", k);
         errors++;
         void'(sig_q.pop_front());
         void'(lat_q.pop_front());
      end else begin
         automatic logic [31:0] es = sig_q.pop_front();
         automatic int el = lat_q.pop_front();
         if (k !== el || sig_a !== es || sigv_a !== 1'b1 || busy_a !== 1'b0) begin
            $display("FAIL single_result: lat %0d sig %h valid %b busy %b, expected %0d %h 1 0",
                     k, sig_a, sigv_a, busy_a, el, es);
            errors++;
         end
      end
   endtask

   task automatic test_abort_capture();
      int seen;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      tick();            // now in CAPTURE
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      checks++;
      if (busy_a !== 1'b0 || sigv_a !== 1'b0 || sig_a !== 32'hFB3EE249) begin
         $display("FAIL abort_capture: busy %b valid %b sig %h, expected 0 0 fb3ee249",
                  busy_a, sigv_a, sig_a);
         errors++;
      end
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (done_a) seen++;
         tick();
      end
      checks++;
      if (seen != 0) begin
         $display("FAIL abort_capture_done: done_o pulsed %0d times, expected 0", seen);
         errors++;
      end
   endtask

   task automatic test_full_sweep();
      int k, bad;
      logic [7:0] ev;
      sig_q.push_back(model_sig(255, 1));
      lat_q.push_back(769);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      k = 0;
      bad = 0;
      while (!done_b && k < 1000) begin
         ev = (k >= 768) ? 8'hFF : 8'(k / 3);
         if (vec_b !== ev) begin
            if (bad == 0) $display("FAIL full_vec at cycle %0d: got %h, expected %h", k, vec_b, ev);
            bad++;
         end
         tick();
         k++;
      end
      checks++;
      if (bad != 0) errors++;
      checks++;
      if (k >= 1000) begin
         $display("FAIL full_timeout: done_o not seen in %0d cycles", k);
         errors++;
         void'(sig_q.pop_front());
         void'(lat_q.pop_front());
      end else begin
         finish_b("full", k);
      end
   endtask

   task automatic test_back_to_back();
      int k;
      logic [31:0] first_sig;
      first_sig = '0;
      for (int run = 0; run < 2; run++) begin
         sig_q.push_back(model_sig(255, 1));
         lat_q.push_back(769);
         start_b = 1'b1;
         tick();
         start_b = 1'b0;
         k = 0;
         while (!done_b && k < 1000) begin
            tick();
            k++;
         end
         if (k >= 1000) begin
            checks++;
            $display("FAIL b2b_timeout run %0d", run);
            errors++;
            void'(sig_q.pop_front());
            void'(lat_q.pop_front());
         end else begin
            finish_b("b2b", k);
         end
         if (run == 0) first_sig = sig_b;
      end
      checks++;
      if (sig_b !== first_sig) begin
         $display("FAIL b2b_repeat: second %h, first %h", sig_b, first_sig);
         errors++;
      end
   endtask

   task automatic test_abort();
      logic [31:0] prior;
      int seen;
      prior = model_sig(255, 1);
      abort_b = 1'b1;    // idle abort must be harmless
      tick();
      abort_b = 1'b0;
      checks++;
      if (sigv_b !== 1'b1 || sig_b !== prior || busy_b !== 1'b0) begin
         $display("FAIL abort_idle: valid %b sig %h busy %b, expected 1 %h 0", sigv_b, sig_b,
                  busy_b, prior);
         errors++;
      end
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      abort_b = 1'b1;
      tick();
      abort_b = 1'b0;
      checks++;
      if (busy_b !== 1'b0 || sigv_b !== 1'b0 || sig_b !== prior) begin
         $display("FAIL abort_run: busy %b valid %b sig %h, expected 0 0 %h", busy_b, sigv_b,
                  sig_b, prior);
         errors++;
      end
      seen = 0;
      for (int k = 0; k < 800; k++) begin
         if (done_b || busy_b) seen++;
         tick();
      end
      checks++;
      if (seen != 0) begin
         $display("FAIL abort_after: done/busy seen %0d cycles, expected 0", seen);
         errors++;
      end
   endtask

   task automatic test_ignored_start();
      int k;
      sig_q.push_back(model_sig(255, 1));
      lat_q.push_back(769);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      k = 0;
      while (!done_b && k < 1000) begin
         start_b = (k == 50 || k == 767) ? 1'b1 : 1'b0;
         tick();
         k++;
      end
      start_b = 1'b0;
      checks++;
      if (k >= 1000) begin
         $display("FAIL ignored_timeout: done_o not seen");
         errors++;
         void'(sig_q.pop_front());
         void'(lat_q.pop_front());
      end else begin
         finish_b("ignored_start", k);
      end
   endtask

   task automatic test_reset_mid();
      int k;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int i = 0; i < 100; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({vec_b, busy_b, done_b, sigv_b, sig_b} !== 43'h0) begin
         $display("FAIL reset_mid: vec %h busy %b done %b valid %b sig %h, expected all 0",
                  vec_b, busy_b, done_b, sigv_b, sig_b);
         errors++;
      end
      sig_q.push_back(model_sig(255, 1));
      lat_q.push_back(769);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      k = 0;
      while (!done_b && k < 1000) begin
         tick();
         k++;
      end
      checks++;
      if (k >= 1000) begin
         $display("FAIL reset_mid_timeout: done_o not seen");
         errors++;
         void'(sig_q.pop_front());
         void'(lat_q.pop_front());
      end else begin
         finish_b("after_reset", k);
      end
   endtask

   task automatic test_toggle();
      int k;
      logic [31:0] es;
      es = model_sig(3, 2);
      start_c = 1'b1;
      tick();
      start_c = 1'b0;
      k = 0;
      while (!done_c && k < 50) begin
         tick();
         k++;
      end
      checks++;
      if (k != 9 || sig_c !== es || sigv_c !== 1'b1) begin
         $display("FAIL four_vec: lat %0d sig %h valid %b, expected 9 %h 1", k, sig_c, sigv_c, es);
         errors++;
      end
`ifdef SWEEP_TOGGLE_CNT_EN
      checks++;
      if (tog_c !== 16'd93) begin
         $display("FAIL toggle_cnt: got %0d, expected 93", tog_c);
         errors++;
      end
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_vector();
      test_abort_capture();
      test_full_sweep();
      test_back_to_back();
      test_abort();
      test_ignored_start();
      test_reset_mid();
      test_toggle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
